// File: rtl/icache_tag_lookup_ctrl.sv
// Tag RAM port controller for the L1.5 I-cache: arbitrates invalidation sweeps,
// refill writes and lookups onto one RAM port and produces the hit/miss result.
module icache_tag_lookup_ctrl #(
    parameter int TAG_WIDTH  = 6,
    parameter int ADDR_WIDTH = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  lookup_req_i,
    input  logic [ADDR_WIDTH-1:0] lookup_index_i,
    input  logic [TAG_WIDTH-1:0]  lookup_tag_i,
    output logic                  lookup_gnt_o,
    output logic                  lookup_rvalid_o,
    output logic                  lookup_hit_o,
    input  logic                  refill_req_i,
    input  logic [ADDR_WIDTH-1:0] refill_index_i,
    input  logic [TAG_WIDTH-1:0]  refill_tag_i,
    output logic                  refill_gnt_o,
    input  logic                  flush_req_i,
    output logic                  flush_busy_o,
    output logic                  tag_req_o,
    output logic                  tag_write_o,
    output logic [ADDR_WIDTH-1:0] tag_addr_o,
    output logic [TAG_WIDTH:0]    tag_wdata_o,
    input  logic [TAG_WIDTH:0]    tag_rdata_i
);

    typedef enum logic {SWEEP, IDLE} state_t;

    typedef struct packed {
        logic                 valid;
        logic [TAG_WIDTH-1:0] tag;
    } tag_entry_t;

    localparam logic [ADDR_WIDTH-1:0] LAST_IDX = '1;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] sweep_cnt_q, sweep_cnt_d;
    logic                  lookup_pend_q, lookup_pend_d;
    logic [TAG_WIDTH-1:0]  lookup_tag_q, lookup_tag_d;
    tag_entry_t            wentry, rentry;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= SWEEP;
            sweep_cnt_q   <= '0;
            lookup_pend_q <= 1'b0;
            lookup_tag_q  <= '0;
        end else begin
            state_q       <= state_d;
            sweep_cnt_q   <= sweep_cnt_d;
            lookup_pend_q <= lookup_pend_d;
            lookup_tag_q  <= lookup_tag_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        sweep_cnt_d   = sweep_cnt_q;
        lookup_pend_d = 1'b0;
        lookup_tag_d  = lookup_tag_q;
        tag_req_o     = 1'b0;
        tag_write_o   = 1'b0;
        tag_addr_o    = sweep_cnt_q;
        wentry        = '0;
        lookup_gnt_o  = 1'b0;
        refill_gnt_o  = 1'b0;
        case (state_q)
            SWEEP: begin
                // Counter wraps to 0 naturally after the last index.
                tag_req_o   = 1'b1;
                tag_write_o = 1'b1;
                sweep_cnt_d = sweep_cnt_q + 1'b1;
                if (sweep_cnt_q == LAST_IDX) state_d = IDLE;
            end
            IDLE: begin
                if (flush_req_i) begin
                    sweep_cnt_d = '0;
                    state_d     = SWEEP;
                end else if (refill_req_i) begin
                    refill_gnt_o = 1'b1;
                    tag_req_o    = 1'b1;
                    tag_write_o  = 1'b1;
                    tag_addr_o   = refill_index_i;
                    wentry       = '{valid: 1'b1, tag: refill_tag_i};
                end else if (lookup_req_i) begin
                    lookup_gnt_o  = 1'b1;
                    tag_req_o     = 1'b1;
                    tag_addr_o    = lookup_index_i;
                    lookup_pend_d = 1'b1;
                    lookup_tag_d  = lookup_tag_i;
                end
            end
            default: state_d = SWEEP;
        endcase
        // Outputs are combinational from state, so keep the port quiet while in reset.
        if (rst) begin
            tag_req_o    = 1'b0;
            lookup_gnt_o = 1'b0;
            refill_gnt_o = 1'b0;
        end
    end

    assign tag_wdata_o     = wentry;
    assign rentry          = tag_entry_t'(tag_rdata_i);
    assign flush_busy_o    = rst | (state_q == SWEEP);
    assign lookup_rvalid_o = lookup_pend_q & ~rst;
    assign lookup_hit_o    = lookup_rvalid_o & rentry.valid & (rentry.tag == lookup_tag_q);

endmodule

// File: tb/tb_icache_tag_lookup_ctrl.sv
// Bench for icache_tag_lookup_ctrl: behavioural tag RAM, vector table for
// refill/lookup traffic, hand sequences for sweep, flush and reset corners.
module tb_icache_tag_lookup_ctrl;
    localparam int TW = 6;
    localparam int AW = 6;
    localparam int DEPTH = 1 << AW;

    logic          clk = 1'b0;
    logic          rst;
    logic          lookup_req, lookup_gnt, lookup_rvalid, lookup_hit;
    logic [AW-1:0] lookup_index, refill_index, tag_addr;
    logic [TW-1:0] lookup_tag, refill_tag;
    logic          refill_req, refill_gnt, flush_req, flush_busy;
    logic          tag_req, tag_write;
    logic [TW:0]   tag_wdata, tag_rdata;

    int total = 0, passed = 0, cyc = 0;
    bit exp_q[$];
    logic [TW:0] mem [DEPTH];

    typedef struct {
        bit            is_refill;
        logic [AW-1:0] idx;
        logic [TW-1:0] tag;
        bit            exp_hit;
    } vec_t;
    vec_t vecs[12];

    icache_tag_lookup_ctrl #(.TAG_WIDTH(TW), .ADDR_WIDTH(AW)) dut (
        .clk(clk), .rst(rst),
        .lookup_req_i(lookup_req), .lookup_index_i(lookup_index), .lookup_tag_i(lookup_tag),
        .lookup_gnt_o(lookup_gnt), .lookup_rvalid_o(lookup_rvalid), .lookup_hit_o(lookup_hit),
        .refill_req_i(refill_req), .refill_index_i(refill_index), .refill_tag_i(refill_tag),
        .refill_gnt_o(refill_gnt), .flush_req_i(flush_req), .flush_busy_o(flush_busy),
        .tag_req_o(tag_req), .tag_write_o(tag_write), .tag_addr_o(tag_addr),
        .tag_wdata_o(tag_wdata), .tag_rdata_i(tag_rdata)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    // One-cycle-latency tag RAM.
    always @(posedge clk) begin
        if (tag_req) begin
            if (tag_write) mem[tag_addr] <= tag_wdata;
            else           tag_rdata     <= mem[tag_addr];
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
    endtask

    // Scoreboard consumer: results must arrive exactly one cycle after a grant.
    bit prev_gnt = 1'b0;
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            prev_gnt = 1'b0;
        end else begin
            if (prev_gnt || lookup_rvalid) check("rvalid_latency", lookup_rvalid, prev_gnt);
            if (lookup_rvalid) begin
                if (exp_q.size() == 0) check("rvalid_unexpected", 1, 0);
                else check("lookup_hit", lookup_hit, exp_q.pop_front());
            end else begin
                check("hit_idle_zero", lookup_hit, 0);
            end
            prev_gnt = lookup_gnt;
        end
    end

    task automatic do_refill(input logic [AW-1:0] idx, input logic [TW-1:0] tag, output int gcyc);
        bit got = 0;
        refill_req = 1'b1; refill_index = idx; refill_tag = tag;
        gcyc = -1;
        for (int k = 0; k < 200 && !got; k++) begin
            @(negedge clk);
            if (refill_gnt) begin got = 1; gcyc = cyc; end
            @(posedge clk); #1;
        end
        if (!got) check("refill_timeout", 0, 1);
        refill_req = 1'b0;
    endtask

    task automatic do_lookup(input logic [AW-1:0] idx, input logic [TW-1:0] tag,
                             input bit exp_hit, output int gcyc);
        bit got = 0;
        lookup_req = 1'b1; lookup_index = idx; lookup_tag = tag;
        gcyc = -1;
        for (int k = 0; k < 200 && !got; k++) begin
            @(negedge clk);
            if (lookup_gnt) begin got = 1; gcyc = cyc; exp_q.push_back(exp_hit); end
            @(posedge clk); #1;
        end
        if (!got) check("lookup_timeout", 0, 1);
        lookup_req = 1'b0;
    endtask

    // Called right after the edge that begins sweep cycle 0; pulses flush at pulse_at.
    task automatic sweep_check(input int n, input int pulse_at);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            check("sweep_cycle",
                  {tag_req, tag_write, lookup_gnt, refill_gnt, flush_busy, tag_addr, tag_wdata},
                  {5'b11001, i[AW-1:0], {(TW+1){1'b0}}});
            flush_req = (i == pulse_at);
        end
        if (n == DEPTH) begin
            @(negedge clk);
            check("busy_fall", flush_busy, 0);
        end
    endtask

    initial begin
        int g1, g2;
        vecs[0]  = '{1'b1, 6'd5,  6'h2A, 1'b0};
        vecs[1]  = '{1'b0, 6'd5,  6'h2A, 1'b1};
        vecs[2]  = '{1'b0, 6'd5,  6'h2B, 1'b0};
        vecs[3]  = '{1'b0, 6'd9,  6'h09, 1'b0};
        vecs[4]  = '{1'b1, 6'd9,  6'h3F, 1'b0};
        vecs[5]  = '{1'b0, 6'd9,  6'h3F, 1'b1};
        vecs[6]  = '{1'b0, 6'd9,  6'h00, 1'b0};
        vecs[7]  = '{1'b0, 6'd63, 6'h15, 1'b0};
        vecs[8]  = '{1'b1, 6'd63, 6'h15, 1'b0};
        vecs[9]  = '{1'b0, 6'd63, 6'h15, 1'b1};
        vecs[10] = '{1'b1, 6'd0,  6'h01, 1'b0};
        vecs[11] = '{1'b0, 6'd0,  6'h01, 1'b1};

        // Garbage valid entries that only a sweep can clear.
        for (int i = 0; i < DEPTH; i++) mem[i] = {1'b1, i[TW-1:0]};
        tag_rdata = '0;
        rst = 1'b1; lookup_req = 0; refill_req = 0; flush_req = 0;
        lookup_index = '0; lookup_tag = '0; refill_index = '0; refill_tag = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_outputs", {tag_req, lookup_gnt, refill_gnt, lookup_rvalid, flush_busy}, 5'b00001);
        @(posedge clk); #1 rst = 1'b0;
        sweep_check(DEPTH, 10);   // flush pulse mid-sweep must be absorbed
        @(posedge clk); #1;

        for (int i = 0; i < 12; i++) begin
            if (vecs[i].is_refill) do_refill(vecs[i].idx, vecs[i].tag, g1);
            else do_lookup(vecs[i].idx, vecs[i].tag, vecs[i].exp_hit, g1);
        end

        // Refill then same-index lookup next cycle; back-to-back lookups.
        do_refill(6'd12, 6'h22, g1);
        do_lookup(6'd12, 6'h22, 1'b1, g2);
        check("refill_lookup_gap", g2 - g1, 1);
        do_lookup(6'd5, 6'h2A, 1'b1, g1);
        do_lookup(6'd12, 6'h23, 1'b0, g2);
        check("b2b_lookup_gap", g2 - g1, 1);

        // All three requests at once: flush wins, then refill, then lookup.
        flush_req = 1; refill_req = 1; refill_index = 6'd3; refill_tag = 6'h11;
        lookup_req = 1; lookup_index = 6'd3; lookup_tag = 6'h11;
        @(negedge clk);
        check("flush_no_grant", {lookup_gnt, refill_gnt, flush_busy}, 3'b000);
        @(posedge clk); #1 flush_req = 0;
        sweep_check(DEPTH, -1);
        check("prio_refill", {refill_gnt, lookup_gnt}, 2'b10);
        @(posedge clk); #1 refill_req = 0;
        @(negedge clk);
        check("prio_lookup", {refill_gnt, lookup_gnt}, 2'b01);
        exp_q.push_back(1'b1);
        @(posedge clk); #1 lookup_req = 0;

        // Flush invalidates an earlier refill.
        flush_req = 1;
        @(posedge clk); #1 flush_req = 0;
        sweep_check(DEPTH, -1);
        @(posedge clk); #1;
        do_lookup(6'd3, 6'h11, 1'b0, g1);

        // Lookup followed by refill of same index: lookup sees pre-write contents.
        do_lookup(6'd7, 6'h06, 1'b0, g1);
        do_refill(6'd7, 6'h06, g2);
        check("lookup_refill_gap", g2 - g1, 1);
        do_lookup(6'd7, 6'h06, 1'b1, g1);
        // Flush right behind a lookup still delivers the result.
        flush_req = 1;
        @(negedge clk);
        check("rvalid_during_flush", lookup_rvalid, 1);
        @(posedge clk); #1 flush_req = 0;
        sweep_check(DEPTH, -1);
        @(posedge clk); #1;

        // Reset right after a grant drops the pending result.
        do_lookup(6'd7, 6'h06, 1'b0, g1);
        rst = 1;
        @(negedge clk);
        check("rst_drop_result", {lookup_rvalid, lookup_hit}, 2'b00);
        @(posedge clk); #1 rst = 0;
        // Reset at sweep counter 20 restarts the sweep from 0.
        sweep_check(20, -1);
        @(posedge clk); #1 rst = 1;
        @(negedge clk);
        check("rst_mid_sweep", {tag_req, lookup_gnt, refill_gnt, lookup_rvalid, flush_busy}, 5'b00001);
        @(posedge clk); #1 rst = 0;
        sweep_check(DEPTH, -1);

        repeat (3) @(posedge clk);
        check("scoreboard_empty", exp_q.size(), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
